// File: rtl/board_draw_sequencer.sv
// Walks the board RAM row-major and asks the box drawer to paint one box per cell,
// using the drawer's start/busy/done handshake. Redraw requests made mid-frame are merged into one pending frame.
module board_draw_sequencer #(
  parameter int         COLS       = 10,
  parameter int         ROWS       = 20,
  parameter int         CELL_W     = 64,
  parameter int         CELL_H     = 24,
  parameter int         ORIGIN_X   = 0,
  parameter int         ORIGIN_Y   = 0,
  parameter logic [8:0] BG_COLOR   = 9'b000_000_000,
  parameter bit         SKIP_EMPTY = 1'b0
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       frame_req,
  output logic [7:0] rd_addr,
  input  logic [2:0] rd_data,
  output logic       box_start,
  output logic [9:0] box_x0,
  output logic [8:0] box_y0,
  output logic [8:0] box_color,
  input  logic       box_done,
  output logic       frame_busy,
  output logic       frame_done
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LATCH,
    ISSUE,
    WAIT,
    NEXT,
    FIN
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          pending;
  logic          col_last;
  logic          row_last;
  logic          start_frame;
  logic          cell_empty;

  function automatic logic [8:0] palette(input logic [2:0] cell_type);
    logic [8:0] c;
    case (cell_type)
      3'd1:    c = 9'b000_111_111;
      3'd2:    c = 9'b111_111_000;
      3'd3:    c = 9'b101_000_101;
      3'd4:    c = 9'b000_111_000;
      3'd5:    c = 9'b111_000_000;
      3'd6:    c = 9'b000_000_111;
      3'd7:    c = 9'b111_100_000;
      default: c = BG_COLOR;
    endcase
    return c;
  endfunction

  assign col_last    = (col == CW'(COLS - 1));
  assign row_last    = (row == RW'(ROWS - 1));
  assign cell_empty  = (rd_data == 3'd0);
  // A frame starts from IDLE on a request, or back-to-back from FIN when one is queued.
  assign start_frame = ((state == IDLE) && frame_req) ||
                       ((state == FIN) && (pending || frame_req));

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_req) state_next = RD;
      RD:      state_next = LATCH;
      LATCH:   state_next = (SKIP_EMPTY && cell_empty) ? NEXT : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (box_done) state_next = NEXT;
      NEXT:    state_next = (col_last && row_last) ? FIN : RD;
      FIN:     state_next = (pending || frame_req) ? RD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    box_start  = 1'b0;
    frame_done = 1'b0;
    frame_busy = 1'b0;
    case (state)
      ISSUE: begin
        box_start  = 1'b1;
        frame_busy = 1'b1;
      end
      RD, LATCH, WAIT, NEXT: frame_busy = 1'b1;
      FIN:   frame_done = 1'b1;
      default: ;
    endcase
  end

  // Coordinates are stepped by addition only; they stay frozen from ISSUE to box_done
  // because the drawer reads them live while painting.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      rd_addr   <= 8'd0;
      col       <= '0;
      row       <= '0;
      box_x0    <= 10'(ORIGIN_X);
      box_y0    <= 9'(ORIGIN_Y);
      box_color <= 9'd0;
      pending   <= 1'b0;
    end else begin
      if (start_frame) begin
        rd_addr <= 8'd0;
        col     <= '0;
        row     <= '0;
        box_x0  <= 10'(ORIGIN_X);
        box_y0  <= 9'(ORIGIN_Y);
      end

      if (state == LATCH) begin
        box_color <= palette(rd_data);
      end

      if ((state == NEXT) && !(col_last && row_last)) begin
        rd_addr <= rd_addr + 8'd1;
        if (col_last) begin
          col    <= '0;
          row    <= row + RW'(1);
          box_x0 <= 10'(ORIGIN_X);
          box_y0 <= box_y0 + 9'(CELL_H);
        end else begin
          col    <= col + CW'(1);
          box_x0 <= box_x0 + 10'(CELL_W);
        end
      end

      if (state == FIN) begin
        pending <= 1'b0;
      end else if (frame_req && (state != IDLE)) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_board_draw_sequencer.sv
// Scoreboard bench: three sequencer variants (2x2, default 10x20, 2x2 skip-empty) share one
// RAM model; a monitor on the selected variant pops expected boxes on every box_start.
module tb_board_draw_sequencer;

  typedef struct packed {
    logic [7:0] addr;
    logic [9:0] x;
    logic [8:0] y;
    logic [8:0] color;
  } box_t;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] frame_req_v = 3'b000;
  logic [2:0] force_done_v = 3'b000;
  logic [2:0] ram [256];
  int         sel = 0;

  box_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   start_count = 0;
  int   done_count = 0;
  int   cyc = 0;
  int   last_done_cyc = 0;
  int   exp_gap = 2;

  logic       in_box = 1'b0;
  logic       held_bad = 1'b0;
  logic [9:0] held_x;
  logic [8:0] held_y;
  logic [8:0] held_c;

  logic [7:0] s_rd_addr;
  logic       s_box_start;
  logic [9:0] s_box_x0;
  logic [8:0] s_box_y0;
  logic [8:0] s_box_color;
  logic       s_box_done;
  logic       s_frame_busy;
  logic       s_frame_done;

  always #10 CLOCK_50 = ~CLOCK_50;

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int NC = (g == 1) ? 10 : 2;
    localparam int NR = (g == 1) ? 20 : 2;
    localparam bit SK = (g == 2);

    logic [7:0] rd_addr;
    logic [2:0] rd_data;
    logic       box_start;
    logic [9:0] box_x0;
    logic [8:0] box_y0;
    logic [8:0] box_color;
    logic       box_done;
    logic       frame_busy;
    logic       frame_done;
    int         cnt;

    board_draw_sequencer #(
      .COLS(NC), .ROWS(NR), .CELL_W(64), .CELL_H(24),
      .ORIGIN_X(0), .ORIGIN_Y(0), .BG_COLOR(9'b000_000_000), .SKIP_EMPTY(SK)
    ) dut (
      .CLOCK_50  (CLOCK_50),
      .resetn    (resetn),
      .frame_req (frame_req_v[g]),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .box_start (box_start),
      .box_x0    (box_x0),
      .box_y0    (box_y0),
      .box_color (box_color),
      .box_done  (box_done),
      .frame_busy(frame_busy),
      .frame_done(frame_done)
    );

    always @(posedge CLOCK_50) rd_data <= ram[rd_addr];

    // Drawer model: done pulse five cycles after the start it saw, shares resetn.
    always @(posedge CLOCK_50) begin
      if (!resetn) cnt <= 0;
      else if (box_start) cnt <= 5;
      else if (cnt != 0) cnt <= cnt - 1;
    end
    assign box_done = (cnt == 1) || force_done_v[g];
  end

  always_comb begin
    case (sel)
      1: begin
        s_rd_addr = inst[1].rd_addr; s_box_start = inst[1].box_start;
        s_box_x0 = inst[1].box_x0; s_box_y0 = inst[1].box_y0;
        s_box_color = inst[1].box_color; s_box_done = inst[1].box_done;
        s_frame_busy = inst[1].frame_busy; s_frame_done = inst[1].frame_done;
      end
      2: begin
        s_rd_addr = inst[2].rd_addr; s_box_start = inst[2].box_start;
        s_box_x0 = inst[2].box_x0; s_box_y0 = inst[2].box_y0;
        s_box_color = inst[2].box_color; s_box_done = inst[2].box_done;
        s_frame_busy = inst[2].frame_busy; s_frame_done = inst[2].frame_done;
      end
      default: begin
        s_rd_addr = inst[0].rd_addr; s_box_start = inst[0].box_start;
        s_box_x0 = inst[0].box_x0; s_box_y0 = inst[0].box_y0;
        s_box_color = inst[0].box_color; s_box_done = inst[0].box_done;
        s_frame_busy = inst[0].frame_busy; s_frame_done = inst[0].frame_done;
      end
    endcase
  end

  // Monitor: pops the scoreboard on each start, watches the box fields until done,
  // and times frame_done against the last completed box.
  always @(negedge CLOCK_50) begin
    box_t got;
    box_t exp;
    cyc = cyc + 1;
    if (!resetn) begin
      in_box = 1'b0;
    end else begin
      if (in_box) begin
        if (s_box_x0 != held_x || s_box_y0 != held_y || s_box_color != held_c) held_bad = 1'b1;
        if (s_box_done) begin
          n_tests = n_tests + 1;
          if (held_bad) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL box_hold: fields changed before done, now x=%0d y=%0d c=%b, required x=%0d y=%0d c=%b",
                     s_box_x0, s_box_y0, s_box_color, held_x, held_y, held_c);
          end
          in_box = 1'b0;
          last_done_cyc = cyc;
        end
      end
      if (s_box_start) begin
        start_count = start_count + 1;
        got = '{addr: s_rd_addr, x: s_box_x0, y: s_box_y0, color: s_box_color};
        n_tests = n_tests + 1;
        if (exp_q.size() == 0) begin
          n_fail = n_fail + 1;
          $display("[TB] FAIL box_start: unexpected start addr=%0d x=%0d y=%0d c=%b, required none",
                   got.addr, got.x, got.y, got.color);
        end else begin
          exp = exp_q.pop_front();
          if (got != exp) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL box_start: got addr=%0d x=%0d y=%0d c=%b, required addr=%0d x=%0d y=%0d c=%b",
                     got.addr, got.x, got.y, got.color, exp.addr, exp.x, exp.y, exp.color);
          end
        end
        in_box = 1'b1;
        held_bad = 1'b0;
        held_x = s_box_x0;
        held_y = s_box_y0;
        held_c = s_box_color;
      end
      if (s_frame_done) begin
        done_count = done_count + 1;
        n_tests = n_tests + 1;
        if (cyc - last_done_cyc != exp_gap) begin
          n_fail = n_fail + 1;
          $display("[TB] FAIL frame_done_gap: got %0d cycles after last box_done, required %0d",
                   cyc - last_done_cyc, exp_gap);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests = n_tests + 1;
    if (actual !== expected) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int which);
    @(posedge CLOCK_50); #1;
    frame_req_v[which] = 1'b1;
    @(posedge CLOCK_50); #1;
    frame_req_v[which] = 1'b0;
  endtask

  task automatic pushBox(input int addr, input int x, input int y, input logic [8:0] color);
    exp_q.push_back('{addr: 8'(addr), x: 10'(x), y: 9'(y), color: color});
  endtask

  task automatic waitStarts(input int target, input int budget);
    int n = 0;
    while (start_count < target && n < budget) begin
      @(posedge CLOCK_50);
      n++;
    end
    if (start_count < target) begin
      n_tests = n_tests + 1;
      n_fail = n_fail + 1;
      $display("[TB] FAIL wait_start: got %0d starts, required %0d", start_count, target);
    end
  endtask

  task automatic waitFrames(input int target, input int budget);
    int n = 0;
    while (done_count < target && n < budget) begin
      @(posedge CLOCK_50);
      n++;
    end
    if (done_count < target) begin
      n_tests = n_tests + 1;
      n_fail = n_fail + 1;
      $display("[TB] FAIL wait_frame: got %0d frame_done, required %0d", done_count, target);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rd_addr"}, 32'(s_rd_addr), 0);
    checkOutput({tag, "_box_start"}, 32'(s_box_start), 0);
    checkOutput({tag, "_box_x0"}, 32'(s_box_x0), 0);
    checkOutput({tag, "_box_y0"}, 32'(s_box_y0), 0);
    checkOutput({tag, "_box_color"}, 32'(s_box_color), 0);
    checkOutput({tag, "_frame_busy"}, 32'(s_frame_busy), 0);
    checkOutput({tag, "_frame_done"}, 32'(s_frame_done), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 3'd0;
    resetn = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkResetValues("reset");
    resetn = 1'b1;

    // 2x2 board with one colour per cell.
    sel = 0; exp_gap = 2;
    ram[0] = 3'd1; ram[1] = 3'd2; ram[2] = 3'd3; ram[3] = 3'd4;
    pushBox(0, 0, 0, 9'b000_111_111);
    pushBox(1, 64, 0, 9'b111_111_000);
    pushBox(2, 0, 24, 9'b101_000_101);
    pushBox(3, 64, 24, 9'b000_111_000);
    applyStimulus(0);
    checkOutput("busy_in_frame", 32'(s_frame_busy), 1);
    waitFrames(1, 200);
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkOutput("small_starts", start_count, 4);
    checkOutput("small_frames", done_count, 1);
    checkOutput("small_queue", exp_q.size(), 0);
    checkOutput("small_busy_after", 32'(s_frame_busy), 0);

    // Full default board, every cell type 5.
    sel = 1; exp_gap = 2;
    for (int i = 0; i < 200; i++) ram[i] = 3'd5;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        pushBox(r * 10 + c, c * 64, r * 24, 9'b111_000_000);
    applyStimulus(1);
    waitFrames(2, 5000);
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkOutput("big_starts", start_count, 204);
    checkOutput("big_frames", done_count, 2);
    checkOutput("big_last_x", 32'(s_box_x0), 576);
    checkOutput("big_last_y", 32'(s_box_y0), 456);

    // Skip-empty variant: only cell 1 is painted.
    sel = 2; exp_gap = 8;
    ram[0] = 3'd0; ram[1] = 3'd7; ram[2] = 3'd0; ram[3] = 3'd0;
    pushBox(1, 64, 0, 9'b111_100_000);
    applyStimulus(2);
    waitFrames(3, 200);
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkOutput("skip_starts", start_count, 205);
    checkOutput("skip_frames", done_count, 3);

    // Two requests during the first WAIT merge into exactly one follow-on frame.
    sel = 0; exp_gap = 2;
    ram[0] = 3'd1; ram[1] = 3'd2; ram[2] = 3'd3; ram[3] = 3'd4;
    for (int f = 0; f < 2; f++) begin
      pushBox(0, 0, 0, 9'b000_111_111);
      pushBox(1, 64, 0, 9'b111_111_000);
      pushBox(2, 0, 24, 9'b101_000_101);
      pushBox(3, 64, 24, 9'b000_111_000);
    end
    applyStimulus(0);
    waitStarts(206, 100);
    #1;
    frame_req_v[0] = 1'b1;
    @(posedge CLOCK_50); #1;
    frame_req_v[0] = 1'b0;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50); #1;
    frame_req_v[0] = 1'b1;
    @(posedge CLOCK_50); #1;
    frame_req_v[0] = 1'b0;
    waitFrames(5, 400);
    repeat (60) @(posedge CLOCK_50);
    #1;
    checkOutput("merge_frames", done_count, 5);
    checkOutput("merge_starts", start_count, 213);
    checkOutput("merge_queue", exp_q.size(), 0);
    checkOutput("merge_busy_after", 32'(s_frame_busy), 0);

    // Stray box_done while idle must be ignored.
    force_done_v[0] = 1'b1;
    @(posedge CLOCK_50); #1;
    force_done_v[0] = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkOutput("spurious_busy", 32'(s_frame_busy), 0);
    checkOutput("spurious_starts", start_count, 213);
    checkOutput("spurious_rd_addr", 32'(s_rd_addr), 3);
    checkOutput("spurious_x0", 32'(s_box_x0), 64);
    checkOutput("spurious_y0", 32'(s_box_y0), 24);

    // Reset during cell 1's WAIT drops the frame and the queued request.
    pushBox(0, 0, 0, 9'b000_111_111);
    pushBox(1, 64, 0, 9'b111_111_000);
    applyStimulus(0);
    waitStarts(214, 100);
    #1;
    frame_req_v[0] = 1'b1;
    @(posedge CLOCK_50); #1;
    frame_req_v[0] = 1'b0;
    waitStarts(215, 100);
    #1;
    resetn = 1'b0;
    @(posedge CLOCK_50); #1;
    resetn = 1'b1;
    checkResetValues("midreset");
    repeat (40) @(posedge CLOCK_50);
    #1;
    checkOutput("midreset_starts", start_count, 215);
    checkOutput("midreset_frames", done_count, 5);
    checkOutput("midreset_busy", 32'(s_frame_busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
